// File: rtl/serial_rx_shifter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : serial_rx_shifter_pkg
//  Purpose  : Shared types for the serial receive/transmit shifters: the
//             frame state encoding and the bit-counter width helper.
//  Revision : 1.0  initial release
// ============================================================================
package serial_rx_shifter_pkg;

   // Frame sequencing states shared by the receive and transmit shifters
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } shift_state_t;

   // Counter width able to hold every value 0..max_n inclusive
   function automatic int calc_ctr_size(input int max_n);
      return $clog2(max_n + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/serial_rx_shifter_edge_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : edge_sync
//  Purpose  : Multi-stage synchroniser for an asynchronous level, plus a
//             free-running history flop that yields a rising-edge pulse.
//  Revision : 1.0  initial release
// ============================================================================
module edge_sync
   import serial_rx_shifter_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_async,
   output logic o_level,
   output logic o_rise
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;

   // Shift the async level through the synchroniser; history trails the last stage
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  = o_level & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/serial_rx_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : serial_rx_shifter
//  Purpose  : Receives one frame of i_n_val bits (MSB first) from an
//             asynchronous bus clock/data pair into a right-aligned word,
//             reporting the running bit count and a one-cycle done pulse.
//  Revision : 1.0  initial release
// ============================================================================
module serial_rx_shifter
   import serial_rx_shifter_pkg::*;
#(
   parameter  int MAX_N       = 8,
   parameter  int SYNC_STAGES = 2,
   localparam int CTR_SIZE    = calc_ctr_size(MAX_N)
) (
   input  logic                i_sys_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   input  logic [CTR_SIZE-1:0] i_n_val,
   input  logic                i_bus_clk,
   input  logic                i_bus_data,
   output logic [MAX_N-1:0]    o_data_out,
   output logic [CTR_SIZE-1:0] o_bit_cnt,
   output logic                o_busy,
   output logic                o_done_sig
);

   shift_state_t        r_state;
   shift_state_t        w_state_next;
   logic [CTR_SIZE-1:0] r_n_lat;
   logic [CTR_SIZE-1:0] r_bit_cnt;
   logic [MAX_N-1:0]    r_shift;
   logic [MAX_N-1:0]    r_data_out;
   logic                r_done;

   logic                w_bus_rise;
   logic                w_bus_level_unused;
   logic                w_data_level;
   logic                w_data_rise_unused;
   logic                w_start_ok;
   logic [CTR_SIZE-1:0] w_cnt_inc;
   logic                w_last_bit;
   logic [MAX_N-1:0]    w_mask;

   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
      .i_clk   (i_sys_clk),
      .i_rst_n (i_rst_n),
      .i_async (i_bus_clk),
      .o_level (w_bus_level_unused),
      .o_rise  (w_bus_rise)
   );

   // Same depth as the clock path so the sampled bit lines up with the edge
   edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_data (
      .i_clk   (i_sys_clk),
      .i_rst_n (i_rst_n),
      .i_async (i_bus_data),
      .o_level (w_data_level),
      .o_rise  (w_data_rise_unused)
   );

   assign w_start_ok = i_start && (i_n_val != '0) && (i_n_val <= CTR_SIZE'(MAX_N));
   assign w_cnt_inc  = r_bit_cnt + CTR_SIZE'(1);
   assign w_last_bit = w_bus_rise && (w_cnt_inc == r_n_lat);

   // Keep only the low r_n_lat bits of the shift register
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < MAX_N; i++) begin
         w_mask[i] = (CTR_SIZE'(i) < r_n_lat);
      end
   end

   // Next-state decode for the frame sequencer
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_IDLE:  if (w_start_ok) w_state_next = ST_SHIFT;
         ST_SHIFT: if (w_last_bit) w_state_next = ST_DONE;
         ST_DONE:  w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   // Frame sequencer state register
   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Length latch, shift register, bit counter and result/done registers
   always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_n_lat    <= '0;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
         r_data_out <= '0;
         r_done     <= 1'b0;
      end else begin
         r_done <= (r_state == ST_DONE);
         if (r_state == ST_IDLE && w_start_ok) begin
            r_n_lat   <= i_n_val;
            r_bit_cnt <= '0;
            r_shift   <= '0;
         end else if (r_state == ST_SHIFT && w_bus_rise) begin
            r_shift   <= {r_shift[MAX_N-2:0], w_data_level};
            r_bit_cnt <= w_cnt_inc;
         end
         if (r_state == ST_DONE) begin
            r_data_out <= r_shift & w_mask;
         end
      end
   end

   assign o_data_out = r_data_out;
   assign o_bit_cnt  = r_bit_cnt;
   assign o_done_sig = r_done;
   // Busy covers the done cycle so it falls only after done_sig
   assign o_busy     = (r_state != ST_IDLE) || r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_rx_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_serial_rx_shifter
//  Purpose  : Self-checking bench for serial_rx_shifter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_rx_shifter;

   localparam int MAX_N    = 8;
   localparam int CTR_SIZE = 4;

   logic                clk      = 1'b0;
   logic                rst_n    = 1'b0;
   logic                start    = 1'b0;
   logic [CTR_SIZE-1:0] n_val    = '0;
   logic                bus_clk  = 1'b0;
   logic                bus_data = 1'b0;
   logic [MAX_N-1:0]    data_out;
   logic [CTR_SIZE-1:0] bit_cnt;
   logic                busy;
   logic                done_sig;

   int n_cmp = 0;
   int n_bad = 0;

   // Monitor state
   int               done_cnt = 0;
   logic [MAX_N-1:0] cap_data = '0;
   logic [CTR_SIZE-1:0] cap_cnt = '0;
   logic             busy_after_done = 1'b1;
   logic             prev_done = 1'b0;

   typedef struct {
      int         n;
      logic [7:0] word;
      logic [7:0] exp;
      int         inj;
      bit         hi;
   } vec_t;

   vec_t tbl[7];

   serial_rx_shifter #(.MAX_N(MAX_N), .SYNC_STAGES(2)) dut (
      .i_sys_clk  (clk),
      .i_rst_n    (rst_n),
      .i_start    (start),
      .i_n_val    (n_val),
      .i_bus_clk  (bus_clk),
      .i_bus_data (bus_data),
      .o_data_out (data_out),
      .o_bit_cnt  (bit_cnt),
      .o_busy     (busy),
      .o_done_sig (done_sig)
   );

   always #41 clk = ~clk;

   // Sample outputs on the falling edge, away from the active edge
   always @(negedge clk) begin
      if (prev_done) busy_after_done = busy;
      prev_done = done_sig;
      if (done_sig) begin
         done_cnt = done_cnt + 1;
         cap_data = data_out;
         cap_cnt  = bit_cnt;
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input bit b, input bit rnd);
      int lo;
      int hi;
      lo = rnd ? int'($urandom_range(300, 700)) : 500;
      hi = rnd ? int'($urandom_range(300, 700)) : 500;
      bus_data = b;
      #(lo);
      bus_clk = 1'b1;
      #(hi);
      bus_clk = 1'b0;
   endtask

   task automatic pulse_start(input int n);
      @(negedge clk);
      start = 1'b1;
      n_val = CTR_SIZE'(n);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Expected word: bits arrive MSB first, so each new bit lands in the LSB
   function automatic logic [7:0] model_word(input bit q[$]);
      int e;
      e = 0;
      foreach (q[k]) e = e * 2 + int'(q[k]);
      return 8'(e);
   endfunction

   task automatic run_frame(input string tag, input int n, input bit bits[$],
                            input logic [7:0] exp, input int inj, input bit hi, input bit rnd);
      int d0;
      bit seen;
      if (hi) begin
         bus_clk = 1'b1;
         repeat (6) @(negedge clk);
      end
      d0 = done_cnt;
      pulse_start(n);
      check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
      if (hi) begin
         repeat (6) @(negedge clk);
         bus_clk = 1'b0;
      end
      foreach (bits[k]) begin
         if (k == inj) pulse_start(2);
         send_bit(bits[k], rnd);
      end
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (done_cnt != d0) seen = 1'b1;
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      repeat (3) @(negedge clk);
      check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
      check({tag, "_data_out"}, 32'(cap_data), 32'(exp));
      check({tag, "_bit_cnt"}, 32'(cap_cnt), 32'(n));
      check({tag, "_busy_after_done"}, 32'(busy_after_done), 32'd0);
   endtask

   task automatic run_vec(input int i);
      bit q[$];
      q.delete();
      for (int k = tbl[i].n - 1; k >= 0; k--) q.push_back(tbl[i].word[k]);
      run_frame($sformatf("vec%0d", i), tbl[i].n, q, tbl[i].exp, tbl[i].inj, tbl[i].hi, 1'b0);
   endtask

   initial begin
      int d0;
      logic [7:0] hold_data;
      logic [CTR_SIZE-1:0] hold_cnt;

      tbl[0] = '{n: 7, word: 8'h59, exp: 8'h59, inj: -1, hi: 1'b0};
      tbl[1] = '{n: 8, word: 8'hA5, exp: 8'hA5, inj: -1, hi: 1'b0};
      tbl[2] = '{n: 3, word: 8'h05, exp: 8'h05, inj: -1, hi: 1'b0};
      tbl[3] = '{n: 5, word: 8'h16, exp: 8'h16, inj: 2,  hi: 1'b0};
      tbl[4] = '{n: 4, word: 8'h0D, exp: 8'h0D, inj: -1, hi: 1'b1};
      tbl[5] = '{n: 1, word: 8'h01, exp: 8'h01, inj: -1, hi: 1'b0};
      tbl[6] = '{n: 2, word: 8'h02, exp: 8'h02, inj: -1, hi: 1'b0};

      // Power-on reset values
      repeat (3) @(negedge clk);
      check("reset_data_out", 32'(data_out), 32'd0);
      check("reset_bit_cnt", 32'(bit_cnt), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done_sig), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 2; i++) run_vec(i);

      // Out-of-range lengths are ignored
      foreach (tbl[i]) begin end
      for (int k = 0; k < 2; k++) begin
         d0 = done_cnt;
         pulse_start(k == 0 ? 0 : 9);
         repeat (4) @(negedge clk);
         check($sformatf("invalid%0d_busy", k), 32'(busy), 32'd0);
         check($sformatf("invalid%0d_data_out", k), 32'(data_out), 32'hA5);
         check($sformatf("invalid%0d_bit_cnt", k), 32'(bit_cnt), 32'd8);
         check($sformatf("invalid%0d_no_done", k), 32'(done_cnt - d0), 32'd0);
      end

      // Asynchronous reset in the middle of an 8-bit frame
      d0 = done_cnt;
      pulse_start(8);
      for (int k = 0; k < 4; k++) send_bit(k[0], 1'b0);
      #13;
      rst_n = 1'b0;
      #1;
      check("midrst_data_out", 32'(data_out), 32'd0);
      check("midrst_bit_cnt", 32'(bit_cnt), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done_sig), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
      check("midrst_busy_after", 32'(busy), 32'd0);
      check("midrst_data_after", 32'(data_out), 32'd0);

      for (int i = 2; i < 7; i++) run_vec(i);

      // Bus clock edges while idle change nothing
      hold_data = data_out;
      hold_cnt  = bit_cnt;
      d0 = done_cnt;
      for (int k = 0; k < 3; k++) send_bit(1'b1, 1'b0);
      repeat (5) @(negedge clk);
      check("idle_edges_data_out", 32'(data_out), 32'(hold_data));
      check("idle_edges_bit_cnt", 32'(bit_cnt), 32'(hold_cnt));
      check("idle_edges_busy", 32'(busy), 32'd0);
      check("idle_edges_no_done", 32'(done_cnt - d0), 32'd0);

      // Randomised frames against the reference model
      for (int r = 0; r < 12; r++) begin
         bit q[$];
         int n;
         n = int'($urandom_range(1, MAX_N));
         q.delete();
         for (int k = 0; k < n; k++) q.push_back(1'($urandom_range(0, 1)));
         run_frame($sformatf("rand%0d", r), n, q, model_word(q), -1, 1'b0, 1'b1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
